// File: rtl/cobra_run_ctrl.sv
// Run/halt/step controller for the CYBERcobra core: gates PC/RF updates through
// core_en_o, sequences core reset and stops free run on breakpoint or budget.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RST_HOLD | core held in reset while the hold down-counter drains
//   HALTED   | idle, accepting host commands, core frozen
//   RUN      | free run until HALT, RESET, breakpoint or budget
//   STEP     | retire exactly one instruction, then back to HALTED
module cobra_run_ctrl #(
  parameter int RST_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_i,
  output logic        cmd_ready_o,
  input  logic [31:0] pc_i,
  input  logic        bp_en_i,
  input  logic [31:0] bp_addr_i,
  input  logic [15:0] budget_i,
  output logic        core_en_o,
  output logic        core_rst_o,
  output logic        halted_o,
  output logic [1:0]  state_o,
  output logic [1:0]  halt_cause_o,
  output logic [31:0] instr_cnt_o
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_CYCLES - 1);

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_HALTED   = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_STEP     = 2'd3;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_HALT  = 2'd1;
  localparam logic [1:0] CMD_STEP  = 2'd2;
  localparam logic [1:0] CMD_RESET = 2'd3;

  localparam logic [1:0] CAUSE_RESET  = 2'd0;
  localparam logic [1:0] CAUSE_HOST   = 2'd1;
  localparam logic [1:0] CAUSE_BP     = 2'd2;
  localparam logic [1:0] CAUSE_BUDGET = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic [CW-1:0] hold_cnt_q;
  logic          core_rst_q;
  logic [31:0]   instr_cnt_q;
  logic [15:0]   run_cnt_q;
  logic          skip_bp_q;
  logic          run_start;
  logic          cmd_accept;
  logic          bp_hit;
  logic          bud_hit;

  assign cmd_accept = cmd_valid_i && cmd_ready_o;
  // skip_bp lets a RUN resumed at the breakpoint PC execute that instruction.
  assign bp_hit     = bp_en_i && (pc_i == bp_addr_i) && !skip_bp_q;
  assign bud_hit    = (budget_i != 16'd0) && (run_cnt_q == budget_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RST_HOLD;
      cause_q    <= CAUSE_RESET;
      hold_cnt_q <= HOLD_LOAD;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      core_rst_q <= (state_d == ST_RST_HOLD);
      if (state_q != ST_RST_HOLD && state_d == ST_RST_HOLD)
        hold_cnt_q <= HOLD_LOAD;
      else if (state_q == ST_RST_HOLD && hold_cnt_q != '0)
        hold_cnt_q <= hold_cnt_q - CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    run_start = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (hold_cnt_q == '0) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (cmd_accept) begin
          case (cmd_i)
            CMD_RUN: begin
              state_d   = ST_RUN;
              run_start = 1'b1;
            end
            CMD_STEP:  state_d = ST_STEP;
            CMD_RESET: begin
              state_d = ST_RST_HOLD;
              cause_d = CAUSE_RESET;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cmd_accept && cmd_i == CMD_RESET) begin
          state_d = ST_RST_HOLD;
          cause_d = CAUSE_RESET;
        end else if (cmd_accept && cmd_i == CMD_HALT) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (bud_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BUDGET;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    cmd_ready_o = !rst_i && (state_q == ST_HALTED || state_q == ST_RUN);
    core_en_o   = 1'b0;
    case (state_q)
      ST_RUN:  core_en_o = !bp_hit && !bud_hit &&
                           !(cmd_accept && (cmd_i == CMD_HALT || cmd_i == CMD_RESET));
      ST_STEP: core_en_o = 1'b1;
      default: core_en_o = 1'b0;
    endcase
    // A retirement must never be counted on the edge that resets the core.
    if (rst_i) core_en_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_cnt_q <= '0;
      run_cnt_q   <= '0;
      skip_bp_q   <= 1'b0;
    end else begin
      if (cmd_accept && cmd_i == CMD_RESET)
        instr_cnt_q <= '0;
      else if (core_en_o)
        instr_cnt_q <= instr_cnt_q + 32'd1;

      if (run_start)
        run_cnt_q <= '0;
      else if (core_en_o && run_cnt_q != 16'hFFFF)
        run_cnt_q <= run_cnt_q + 16'd1;

      if (run_start)
        skip_bp_q <= 1'b1;
      else if (state_q == ST_RUN)
        skip_bp_q <= 1'b0;
    end
  end

  assign core_rst_o   = core_rst_q;
  assign halted_o     = (state_q == ST_HALTED);
  assign state_o      = state_q;
  assign halt_cause_o = cause_q;
  assign instr_cnt_o  = instr_cnt_q;

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Directed bench for cobra_run_ctrl with a behavioural PC that steps +4 on
// every enabled cycle and returns to 0 while the core is held in reset.
module tb_cobra_run_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic [1:0]  cmd_i = 2'd0;
  logic        cmd_ready_o;
  logic [31:0] pc_i = 32'd0;
  logic        bp_en_i = 1'b0;
  logic [31:0] bp_addr_i = 32'd0;
  logic [15:0] budget_i = 16'd0;
  logic        core_en_o;
  logic        core_rst_o;
  logic        halted_o;
  logic [1:0]  state_o;
  logic [1:0]  halt_cause_o;
  logic [31:0] instr_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int e0;
  int n;

  localparam logic [1:0] RUN = 2'd0, HALT = 2'd1, STEP = 2'd2, RESET = 2'd3;

  cobra_run_ctrl #(.RST_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
    .cmd_ready_o(cmd_ready_o), .pc_i(pc_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
    .budget_i(budget_i), .core_en_o(core_en_o), .core_rst_o(core_rst_o),
    .halted_o(halted_o), .state_o(state_o), .halt_cause_o(halt_cause_o),
    .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (core_rst_o) pc_i <= 32'd0;
    else if (core_en_o) pc_i <= pc_i + 32'd4;
    if (core_en_o) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid_i = 1'b1;
    cmd_i = c;
    tick();
    cmd_valid_i = 1'b0;
    #1;
  endtask

  task automatic hard_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_halt(input int max);
    int k = 0;
    while (!halted_o && k < max) begin
      tick();
      k++;
    end
    chk("halt_reached", halted_o, 1'b1);
  endtask

  initial begin
    // reset window
    tick();
    chk("rst_core_rst", core_rst_o, 1'b1);
    chk("rst_state", state_o, 2'd0);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_ready", cmd_ready_o, 1'b0);
    chk("rst_en", core_en_o, 1'b0);
    chk("rst_instr", instr_cnt_o, 32'd0);
    rst_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_core_rst", core_rst_o, 1'b1);
      chk("hold_ready", cmd_ready_o, 1'b0);
      tick();
    end
    chk("post_hold_halted", halted_o, 1'b1);
    chk("post_hold_core_rst", core_rst_o, 1'b0);
    chk("post_hold_cause", halt_cause_o, 2'd0);
    chk("post_hold_instr", instr_cnt_o, 32'd0);

    // three single steps
    for (int k = 0; k < 3; k++) begin
      send(STEP);
      chk("step_state", state_o, 2'd3);
      chk("step_en", core_en_o, 1'b1);
      chk("step_ready", cmd_ready_o, 1'b0);
      tick();
      chk("step_back_halted", halted_o, 1'b1);
    end
    chk("step_instr", instr_cnt_o, 32'd3);
    chk("step_pc", pc_i, 32'hC);
    chk("step_final_state", state_o, 2'd1);

    // breakpoint at 0x10, then resume through it
    hard_reset();
    bp_en_i = 1'b1; bp_addr_i = 32'h10; budget_i = 16'd0;
    send(RUN);
    wait_halt(40);
    chk("bp_pc", pc_i, 32'h10);
    chk("bp_instr", instr_cnt_o, 32'd4);
    chk("bp_cause", halt_cause_o, 2'd2);
    send(RUN);
    chk("bp_resume_en", core_en_o, 1'b1);
    chk("bp_resume_pc", pc_i, 32'h10);
    tick();
    chk("bp_resume_pc2", pc_i, 32'h14);
    repeat (3) tick();
    chk("bp_resume_running", state_o, 2'd2);

    // instruction budget of 5, twice
    hard_reset();
    bp_en_i = 1'b0; budget_i = 16'd5;
    e0 = en_cnt;
    send(RUN);
    wait_halt(40);
    chk("bud_en_cycles", en_cnt - e0, 5);
    chk("bud_pc", pc_i, 32'h14);
    chk("bud_cause", halt_cause_o, 2'd3);
    chk("bud_instr", instr_cnt_o, 32'd5);
    send(RUN);
    wait_halt(40);
    chk("bud2_instr", instr_cnt_o, 32'd10);
    chk("bud2_pc", pc_i, 32'h28);

    // host HALT after 7 retirements
    hard_reset();
    budget_i = 16'd0; bp_en_i = 1'b0;
    send(RUN);
    n = 0;
    while (instr_cnt_o != 32'd7 && n < 50) begin
      tick();
      n++;
    end
    chk("halt_pre_instr", instr_cnt_o, 32'd7);
    cmd_valid_i = 1'b1; cmd_i = HALT;
    #1;
    chk("halt_accept_en", core_en_o, 1'b0);
    chk("halt_accept_ready", cmd_ready_o, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    #1;
    chk("halt_halted", halted_o, 1'b1);
    chk("halt_cause", halt_cause_o, 2'd1);
    chk("halt_instr", instr_cnt_o, 32'd7);
    chk("halt_pc", pc_i, 32'h1C);

    // HALT and breakpoint in the same cycle: HALT wins
    hard_reset();
    bp_en_i = 1'b1; bp_addr_i = 32'h8;
    send(RUN);
    tick();
    tick();
    chk("tie_pc", pc_i, 32'h8);
    chk("tie_state", state_o, 2'd2);
    cmd_valid_i = 1'b1; cmd_i = HALT;
    #1;
    chk("tie_en", core_en_o, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    #1;
    chk("tie_cause", halt_cause_o, 2'd1);
    chk("tie_instr", instr_cnt_o, 32'd2);

    // RESET command mid-run
    hard_reset();
    bp_en_i = 1'b0;
    send(RUN);
    repeat (3) tick();
    chk("rcmd_pre_instr", instr_cnt_o, 32'd3);
    cmd_valid_i = 1'b1; cmd_i = RESET;
    #1;
    chk("rcmd_en", core_en_o, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    #1;
    chk("rcmd_state", state_o, 2'd0);
    chk("rcmd_instr", instr_cnt_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rcmd_hold", core_rst_o, 1'b1);
      tick();
    end
    chk("rcmd_halted", halted_o, 1'b1);
    chk("rcmd_pc", pc_i, 32'd0);

    // rst_i asserted during a STEP cycle
    send(STEP);
    chk("rstep_en_before", core_en_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("rstep_en_gated", core_en_o, 1'b0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("rstep_state", state_o, 2'd0);
    chk("rstep_instr", instr_cnt_o, 32'd0);
    chk("rstep_core_rst", core_rst_o, 1'b1);
    chk("rstep_pc", pc_i, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cobra_run_ctrl.md
# cobra_run_ctrl

Run/halt/step controller for the CYBERcobra single-cycle core. It gates architectural state updates (PC and register-file write) through one enable, holds the core in reset for a fixed window, and retires instructions on host commands: free run, single step, or halt. In free run it also stops on a PC breakpoint or an instruction budget. It sits between the host/debug command port and the core's PC/RF enable and reset inputs.

## Interface
Parameters:
- RST_CYCLES, 4: cycles `core_rst_o` is held after `rst_i` or a RESET command (≥1).

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  host command valid
- cmd_i  in  2  command: 0 RUN, 1 HALT, 2 STEP, 3 RESET
- cmd_ready_o  out  1  command accepted when `cmd_valid_i && cmd_ready_o` at a rising edge
- pc_i  in  32  current core PC
- bp_en_i  in  1  breakpoint enable
- bp_addr_i  in  32  breakpoint PC
- budget_i  in  16  max instructions per RUN; 0 = unlimited
- core_en_o  out  1  core may update PC/RF this cycle (combinational)
- core_rst_o  out  1  core reset (registered)
- halted_o  out  1  state == HALTED
- state_o  out  2  0 RST_HOLD, 1 HALTED, 2 RUN, 3 STEP
- halt_cause_o  out  2  0 reset, 1 host HALT, 2 breakpoint, 3 budget
- instr_cnt_o  out  32  retired-instruction counter

## Operation
- States: RST_HOLD, HALTED, RUN, STEP.
- RST_HOLD:
  - `core_rst_o`=1; a down-counter loads RST_CYCLES-1 on entry.
  - At 0 → HALTED; `core_rst_o` drops on the same edge.
  - `cmd_ready_o`=0.
- HALTED:
  - `cmd_ready_o`=1.
  - RUN → RUN; clear `run_cnt`; set `skip_bp`=1.
  - STEP → STEP.
  - RESET → RST_HOLD.
  - HALT → accepted, no effect.
- RUN:
  - `cmd_ready_o`=1.
  - `bp_hit` = `bp_en_i && pc_i==bp_addr_i && !skip_bp`.
  - `bud_hit` = `budget_i!=0 && run_cnt==budget_i`.
  - `core_en_o` = `!bp_hit && !bud_hit && !(accepted HALT or RESET this cycle)`.
  - `skip_bp` clears after the first RUN cycle. Resuming at a breakpoint PC therefore executes that instruction.
  - Exit priority (highest first):
    - RESET → RST_HOLD.
    - HALT → HALTED, cause 1.
    - `bp_hit` → HALTED, cause 2.
    - `bud_hit` → HALTED, cause 3.
  - RUN/STEP commands in RUN are accepted and ignored.
- STEP:
  - `core_en_o`=1 for exactly one cycle; breakpoint and budget are ignored.
  - Next state HALTED; `halt_cause_o` unchanged.
  - `cmd_ready_o`=0.
- `core_en_o`=0 in RST_HOLD and HALTED.
- Counters:
  - `instr_cnt_o` and 16-bit `run_cnt` increment on every cycle with `core_en_o`=1.
  - `instr_cnt_o` wraps at 2^32.
  - `run_cnt` saturates at 0xFFFF.
  - `instr_cnt_o` clears on `rst_i` and on an accepted RESET.
- `budget_i` and `bp_*` are sampled every cycle; changing them mid-RUN takes effect immediately.

## Timing
- `rst_i` has priority over everything.
- On the edge where `rst_i`=1:
  - state → RST_HOLD; `core_rst_o`=1.
  - `instr_cnt_o`=0; `halt_cause_o`=0; `run_cnt`=0; `skip_bp`=0.
  - `core_en_o`=0; `cmd_ready_o`=0; `halted_o`=0; `state_o`=0.
- After `rst_i` deasserts, `core_rst_o` stays high RST_CYCLES cycles, then HALTED.
- Command acceptance registers the next state on the same edge. The first RUN cycle with `core_en_o`=1 is the cycle after acceptance.
- Breakpoint latency: 0. The cycle where `pc_i`==`bp_addr_i` has `core_en_o`=0, so the instruction at `bp_addr_i` is not executed. HALTED follows on the next edge.
- A budget of N retires exactly N instructions per RUN.
- RESET in RUN: `core_en_o`=0 that cycle; RST_HOLD and `core_rst_o`=1 from the next edge.

## Test plan
- Bench model: `pc_i` starts at 0 and advances +4 on each `core_en_o` cycle; it returns to 0 when `core_rst_o`=1.
- Reset with RST_CYCLES=4: `rst_i` 1 cycle → `core_rst_o` high 4 cycles after release, then `halted_o`=1, `halt_cause_o`=0, `instr_cnt_o`=0; `cmd_ready_o` low throughout the hold.
- Three STEP commands: each gives one `core_en_o` pulse; final `instr_cnt_o`=3, `pc_i`=0xC, state HALTED; `cmd_ready_o` low during each STEP cycle.
- RUN from PC 0 with bp 0x10, budget 0: halts with `pc_i`=0x10, `instr_cnt_o`=4, cause 2. A second RUN executes 0x10 and does not stop there.
- RUN with budget 5, bp off, from 0: exactly 5 `core_en_o` cycles, `pc_i`=0x14, cause 3. A second RUN retires 5 more: `instr_cnt_o`=10.
- Unlimited RUN, HALT accepted after 7 retirements: `core_en_o`=0 in the accept cycle, `instr_cnt_o`=7, cause 1. In the same cycle as `bp_hit`, HALT wins (cause 1).
- RESET command mid-RUN: `core_en_o`=0 that cycle, RST_HOLD for 4 cycles, `instr_cnt_o`=0, then HALTED. `rst_i` asserted during STEP → RST_HOLD next edge, no retirement counted.
